// File: rtl/rggen_bus_arbiter.sv
// Shares one rggen register-bus port among HOSTS requesters. The grant is registered and held until the register block completes.
// Define RGGEN_BUS_ARBITER_FIXED_PRIORITY_EN to select fixed priority (lowest index wins) instead of round-robin.
module rggen_bus_arbiter #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [HOSTS-1:0]                  i_host_valid,
    input  logic [2*HOSTS-1:0]                i_host_access,
    input  logic [ADDRESS_WIDTH*HOSTS-1:0]    i_host_address,
    input  logic [BUS_WIDTH*HOSTS-1:0]        i_host_write_data,
    input  logic [STROBE_WIDTH*HOSTS-1:0]     i_host_strobe,
    output logic [HOSTS-1:0]                  o_host_ready,
    output logic [1:0]                        o_host_status,
    output logic [BUS_WIDTH-1:0]              o_host_read_data,
    output logic                              o_bus_valid,
    output logic [1:0]                        o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]          o_bus_address,
    output logic [BUS_WIDTH-1:0]              o_bus_write_data,
    output logic [STROBE_WIDTH-1:0]           o_bus_strobe,
    input  logic                              i_bus_ready,
    input  logic [1:0]                        i_bus_status,
    input  logic [BUS_WIDTH-1:0]              i_bus_read_data,
    output logic [HOSTS-1:0]                  o_grant,
    output logic                              o_state
);

    // Handshake: a transfer completes in the cycle where o_bus_valid && i_bus_ready;
    // the granted host must hold its valid and request fields stable until then.

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [HOSTS-1:0]   grant_q;
    logic [HOSTS-1:0]   grant_d;
    logic [HOSTS-1:0]   pick;
    logic               pick_found;
    logic               granted_valid;
    logic               done;

    assign granted_valid = |(i_host_valid & grant_q);
    assign o_bus_valid   = (state_q == GRANTED) && granted_valid;
    assign done          = o_bus_valid && i_bus_ready;
    assign o_grant       = grant_q;
    assign o_state       = state_q;

`ifdef RGGEN_BUS_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < HOSTS; k++) begin
            if (!pick_found && i_host_valid[k]) begin
                pick[k]    = 1'b1;
                pick_found = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] grant_idx;
    int               rr_idx;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < HOSTS; k++) begin
            if (grant_q[k]) begin
                grant_idx = PTR_W'(k);
            end
        end
    end

    // Search begins just after the last host that completed, wrapping around.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        rr_idx     = 0;
        for (int i = 0; i < HOSTS; i++) begin
            rr_idx = (int'(rr_ptr_q) + 1 + i) % HOSTS;
            if (!pick_found && i_host_valid[rr_idx]) begin
                pick[rr_idx] = 1'b1;
                pick_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q <= PTR_W'(HOSTS - 1);
        end else if (done) begin
            rr_ptr_q <= grant_idx;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // An abandoned request (granted valid dropped before ready) returns to IDLE without a ready.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (done || !granted_valid) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_bus_access     = '0;
        o_bus_address    = '0;
        o_bus_write_data = '0;
        o_bus_strobe     = '0;
        for (int k = 0; k < HOSTS; k++) begin
            if (grant_q[k]) begin
                o_bus_access     = o_bus_access     | i_host_access[2*k+:2];
                o_bus_address    = o_bus_address    | i_host_address[ADDRESS_WIDTH*k+:ADDRESS_WIDTH];
                o_bus_write_data = o_bus_write_data | i_host_write_data[BUS_WIDTH*k+:BUS_WIDTH];
                o_bus_strobe     = o_bus_strobe     | i_host_strobe[STROBE_WIDTH*k+:STROBE_WIDTH];
            end
        end
    end

    // Response fields are zero outside the completion cycle.
    always_comb begin
        o_host_ready     = '0;
        o_host_status    = '0;
        o_host_read_data = '0;
        if (done) begin
            o_host_ready     = grant_q;
            o_host_status    = i_bus_status;
            o_host_read_data = i_bus_read_data;
        end
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Self-checking bench for rggen_bus_arbiter: directed scenarios plus randomized transfers against a transaction-level arbitration model.
module tb_rggen_bus_arbiter;

    localparam int HOSTS = 2;
    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int SW    = BW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [HOSTS-1:0]     host_valid;
    logic [2*HOSTS-1:0]   host_access;
    logic [AW*HOSTS-1:0]  host_address;
    logic [BW*HOSTS-1:0]  host_write_data;
    logic [SW*HOSTS-1:0]  host_strobe;
    logic [HOSTS-1:0]     host_ready;
    logic [1:0]           host_status;
    logic [BW-1:0]        host_read_data;
    logic                 bus_valid;
    logic [1:0]           bus_access;
    logic [AW-1:0]        bus_address;
    logic [BW-1:0]        bus_write_data;
    logic [SW-1:0]        bus_strobe;
    logic                 bus_ready;
    logic [1:0]           bus_status;
    logic [BW-1:0]        bus_read_data;
    logic [HOSTS-1:0]     grant;
    logic                 state;

    logic [1:0]    h_acc  [HOSTS];
    logic [AW-1:0] h_addr [HOSTS];
    logic [BW-1:0] h_data [HOSTS];
    logic [SW-1:0] h_strb [HOSTS];

    int n_cmp = 0;
    int n_err = 0;
    int exp_ptr;
    logic [HOSTS-1:0] exp_q[$];

    always #5 clk = ~clk;

    rggen_bus_arbiter #(
        .HOSTS(HOSTS), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_host_valid(host_valid), .i_host_access(host_access),
        .i_host_address(host_address), .i_host_write_data(host_write_data),
        .i_host_strobe(host_strobe),
        .o_host_ready(host_ready), .o_host_status(host_status),
        .o_host_read_data(host_read_data),
        .o_bus_valid(bus_valid), .o_bus_access(bus_access),
        .o_bus_address(bus_address), .o_bus_write_data(bus_write_data),
        .o_bus_strobe(bus_strobe),
        .i_bus_ready(bus_ready), .i_bus_status(bus_status),
        .i_bus_read_data(bus_read_data),
        .o_grant(grant), .o_state(state)
    );

    // Winner among the requesting hosts, given the host that completed last.
    function automatic int model_pick(input logic [HOSTS-1:0] req, input int last);
        int idx;
`ifdef RGGEN_BUS_ARBITER_FIXED_PRIORITY_EN
        idx = last;
        for (int k = 0; k < HOSTS; k++) if (req[k]) return k;
`else
        for (int i = 1; i <= HOSTS; i++) begin
            idx = (last + i) % HOSTS;
            if (req[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic drive_hosts();
        for (int k = 0; k < HOSTS; k++) begin
            host_access[2*k+:2]        = h_acc[k];
            host_address[AW*k+:AW]     = h_addr[k];
            host_write_data[BW*k+:BW]  = h_data[k];
            host_strobe[SW*k+:SW]      = h_strb[k];
        end
    endtask

    task automatic set_host(input int k, input logic [1:0] acc, input logic [AW-1:0] addr,
                            input logic [BW-1:0] data, input logic [SW-1:0] strb);
        h_acc[k] = acc; h_addr[k] = addr; h_data[k] = data; h_strb[k] = strb;
        drive_hosts();
    endtask

    // Called at a negedge in IDLE with requests already driven; ends at the negedge of the following IDLE cycle.
    task automatic do_transfer(input int waits, input logic [1:0] st, input logic [BW-1:0] rd, input string tag);
        int w;
        logic [HOSTS-1:0] exp_g;
        logic [HOSTS-1:0] got_g;
        w = model_pick(host_valid, exp_ptr);
        n_cmp++; if (w < 0) begin n_err++; $display("FAIL %s_request: got none expected a requester", tag); return; end
        exp_g = HOSTS'(1) << w;
        exp_q.push_back(exp_g);
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            bus_ready     = (c == waits);
            bus_status    = st;
            bus_read_data = rd;
            #1;
            n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL %s_grant: got %b expected %b", tag, grant, exp_g); end
            n_cmp++; if (bus_valid !== 1'b1) begin n_err++; $display("FAIL %s_bus_valid: got %b expected 1", tag, bus_valid); end
            n_cmp++; if (bus_address !== h_addr[w]) begin n_err++; $display("FAIL %s_address: got %h expected %h", tag, bus_address, h_addr[w]); end
            n_cmp++; if (bus_access !== h_acc[w]) begin n_err++; $display("FAIL %s_access: got %b expected %b", tag, bus_access, h_acc[w]); end
            n_cmp++; if (bus_write_data !== h_data[w]) begin n_err++; $display("FAIL %s_write_data: got %h expected %h", tag, bus_write_data, h_data[w]); end
            n_cmp++; if (bus_strobe !== h_strb[w]) begin n_err++; $display("FAIL %s_strobe: got %h expected %h", tag, bus_strobe, h_strb[w]); end
            if (c == waits) begin
                got_g = exp_q.pop_front();
                n_cmp++; if (host_ready !== got_g) begin n_err++; $display("FAIL %s_ready: got %b expected %b", tag, host_ready, got_g); end
                n_cmp++; if (host_status !== st) begin n_err++; $display("FAIL %s_status: got %b expected %b", tag, host_status, st); end
                n_cmp++; if (host_read_data !== rd) begin n_err++; $display("FAIL %s_read_data: got %h expected %h", tag, host_read_data, rd); end
            end else begin
                n_cmp++; if (host_ready !== '0) begin n_err++; $display("FAIL %s_wait_ready: got %b expected 0", tag, host_ready); end
                n_cmp++; if (host_read_data !== '0) begin n_err++; $display("FAIL %s_wait_read_data: got %h expected 0", tag, host_read_data); end
            end
        end
        exp_ptr = w;
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL %s_idle_grant: got %b expected 0", tag, grant); end
        n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL %s_idle_state: got %b expected 0", tag, state); end
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle_valid: got %b expected 0", tag, bus_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        host_valid = '0; bus_ready = 1'b0; bus_status = '0; bus_read_data = '0;
        for (int k = 0; k < HOSTS; k++) set_host(k, 2'b00, '0, '0, '0);
        exp_ptr = HOSTS - 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b expected 0", grant); end
        n_cmp++; if (host_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", host_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_bus_valid: got %b expected 0", bus_valid); end
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL post_reset_grant: got %b expected 0", grant); end
        n_cmp++; if (host_ready !== '0) begin n_err++; $display("FAIL post_reset_ready: got %b expected 0", host_ready); end
        n_cmp++; if (host_status !== '0) begin n_err++; $display("FAIL post_reset_status: got %b expected 0", host_status); end
    endtask

    task automatic test_single_write();
        set_host(1, 2'b11, 8'h10, 32'hDEADBEEF, 4'hF);
        host_valid = 2'b10;
        #1;
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle_valid: got %b expected 0", bus_valid); end
        do_transfer(0, 2'b00, 32'h0, "single_write");
        host_valid = '0;
    endtask

    task automatic test_round_robin();
        set_host(0, 2'b11, 8'h20, 32'h0000_1111, 4'h3);
        set_host(1, 2'b11, 8'h24, 32'h0000_2222, 4'hC);
        host_valid = 2'b11;
        for (int t = 0; t < 4; t++) do_transfer(0, 2'b00, 32'h0, "round_robin");
        host_valid = '0;
    endtask

    task automatic test_wait_read();
        set_host(0, 2'b10, 8'h40, 32'h0, 4'h0);
        set_host(1, 2'b11, 8'h44, 32'hCAFE_F00D, 4'hF);
        host_valid = 2'b11;
        do_transfer(3, 2'b00, 32'h12345678, "wait_read");
        host_valid = 2'b10;
        do_transfer(1, 2'b01, 32'h0, "after_wait_read");
        host_valid = '0;
    endtask

    task automatic test_abandon();
        set_host(0, 2'b10, 8'h50, 32'h0, 4'h0);
        host_valid = 2'b01;
        @(negedge clk); #1;
        n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL abandon_grant: got %b expected 01", grant); end
        @(negedge clk); #1;
        n_cmp++; if (bus_valid !== 1'b1) begin n_err++; $display("FAIL abandon_wait_valid: got %b expected 1", bus_valid); end
        host_valid = '0;
        #1;
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL abandon_valid_drop: got %b expected 0", bus_valid); end
        n_cmp++; if (host_ready !== '0) begin n_err++; $display("FAIL abandon_ready: got %b expected 0", host_ready); end
        @(negedge clk); #1;
        n_cmp++; if (state !== 1'b0) begin n_err++; $display("FAIL abandon_state: got %b expected 0", state); end
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL abandon_idle_grant: got %b expected 0", grant); end
        set_host(1, 2'b11, 8'h54, 32'h5555_AAAA, 4'h1);
        host_valid = 2'b11;
        do_transfer(0, 2'b00, 32'h0, "abandon_pointer");
        host_valid = '0;
    endtask

    task automatic test_reset_mid();
        set_host(1, 2'b11, 8'h60, 32'h6666_6666, 4'hF);
        set_host(0, 2'b10, 8'h64, 32'h0, 4'h0);
        host_valid = 2'b10;
        @(negedge clk); #1;
        n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL reset_mid_grant: got %b expected 10", grant); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b expected 0", bus_valid); end
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_mid_grant_clear: got %b expected 0", grant); end
        n_cmp++; if (host_ready !== '0) begin n_err++; $display("FAIL reset_mid_ready: got %b expected 0", host_ready); end
        exp_ptr = HOSTS - 1;
        exp_q.delete();
        host_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        do_transfer(0, 2'b00, 32'h0, "reset_mid_first");
        host_valid = '0;
    endtask

    task automatic test_random();
        logic [HOSTS-1:0] mask;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < HOSTS; k++)
                set_host(k, 2'($urandom_range(1, 3)), AW'($urandom), BW'($urandom), SW'($urandom));
            mask = HOSTS'($urandom_range(0, (1 << HOSTS) - 1));
            host_valid = mask;
            if (mask == '0) begin
                @(negedge clk); #1;
                n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL random_no_request_grant: got %b expected 0", grant); end
            end else begin
                do_transfer($urandom_range(0, 3), 2'($urandom), BW'($urandom), "random");
            end
        end
        host_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_read();
        test_abandon();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one rggen register-bus port (valid/access/address/write_data/strobe in; ready/status/read_data out) among HOSTS requesters.
- Sits upstream of the bus-side port of the register-block adapter logic, so several host protocol bridges (e.g. APB plus a debug port) can reach one register block.
- Arbitration is round-robin by default. The grant is registered and held until the register block returns ready.

Parameters:
- HOSTS, 2: number of requesters; minimum 1.
- ADDRESS_WIDTH, 8: bus address width.
- BUS_WIDTH, 32: data width.
- STROBE_WIDTH, BUS_WIDTH/8: byte-strobe width.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset.
- i_host_valid  input  HOSTS  per-host request valid.
- i_host_access  input  2*HOSTS  per-host access code; host k uses bits [2k+:2].
- i_host_address  input  ADDRESS_WIDTH*HOSTS  per-host address.
- i_host_write_data  input  BUS_WIDTH*HOSTS  per-host write data.
- i_host_strobe  input  STROBE_WIDTH*HOSTS  per-host byte strobe.
- o_host_ready  input-to-host  HOSTS  one-hot completion pulse to the granted host.
- o_host_status  output  2  response status, shared by all hosts, valid only with o_host_ready.
- o_host_read_data  output  BUS_WIDTH  response read data, shared by all hosts, valid only with o_host_ready.
- o_bus_valid  output  1  downstream valid.
- o_bus_access  output  2  downstream access code.
- o_bus_address  output  ADDRESS_WIDTH  downstream address.
- o_bus_write_data  output  BUS_WIDTH  downstream write data.
- o_bus_strobe  output  STROBE_WIDTH  downstream byte strobe.
- i_bus_ready  input  1  downstream completion.
- i_bus_status  input  2  downstream status.
- i_bus_read_data  input  BUS_WIDTH  downstream read data.
- o_grant  output  HOSTS  current one-hot grant (observability).

Interface decision: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.

Behaviour:
- State machine has two states, IDLE and GRANTED. Reset state is IDLE.
- Reset values:
  - grant register = 0; o_grant = 0, o_bus_valid = 0, o_host_ready = 0.
  - Round-robin pointer = HOSTS-1, so host 0 has top priority first.
- IDLE:
  - No downstream valid.
  - If any i_host_valid is set, latch a one-hot grant for the winner and go to GRANTED on the next edge.
  - Round-robin search starts at (pointer+1) mod HOSTS and wraps around.
- GRANTED:
  - o_bus_valid = i_host_valid[g] for granted host g.
  - o_bus_access, o_bus_address, o_bus_write_data and o_bus_strobe are muxed from host g, combinationally.
- Completion in GRANTED:
  - i_bus_ready && o_bus_valid pulses o_host_ready[g] in the same cycle.
  - The same cycle forwards i_bus_status / i_bus_read_data to o_host_status / o_host_read_data.
  - pointer <= g; grant cleared; next state IDLE.
- Latency: one arbitration cycle from host valid to downstream valid. A zero-wait register block gives ready at cycle 1, so each transfer takes at least 2 cycles.
- Back-to-back: an IDLE cycle always separates transfers. A host holding valid after its ready is re-arbitrated against the others and does not win again while another host is requesting.
- Abandon: if i_host_valid[g] drops in GRANTED before ready, o_bus_valid drops, grant clears and the state returns to IDLE. No ready is issued and the pointer is unchanged. This is a protocol violation by the host; the arbiter recovers without hanging.
- Hosts must hold valid and request fields stable until ready.
- While o_host_ready is 0, o_host_status and o_host_read_data are 0.
- HOSTS=1: the same FSM applies, with grant always bit 0.
- Reset asserted mid-transfer clears all state immediately. Downstream valid drops asynchronously.
- Only the granted host's ready bit can ever be 1.

Optional Feature:
- Macro: RGGEN_BUS_ARBITER_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins. The pointer register is not implemented, and grant is held until completion exactly as in round-robin mode.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. Reset with all hosts idle: o_bus_valid=0, o_grant=0 and o_host_ready=0 both during reset and after release.
2. Host 1 alone writes addr 0x10, data 0xDEADBEEF, strobe 0xF; register block has 0 wait states:
   - cycle 1: o_bus_valid=1 with host 1 fields;
   - i_bus_ready then gives o_host_ready=2'b10, status 2'b00;
   - FSM back in IDLE on the next cycle.
3. Hosts 0 and 1 both hold valid continuously, HOSTS=2, round-robin:
   - grants alternate 0,1,0,1 across four transfers;
   - with FIXED_PRIORITY_EN defined, host 0 wins all four.
4. Granted host 0 read with 3 wait states while host 1 requests:
   - grant stays 2'b01 for all 3 wait cycles;
   - o_host_read_data = i_bus_read_data (0x12345678) only in the ready cycle;
   - host 1 is granted next.
5. Host 0 drops valid after 1 wait cycle: o_bus_valid falls, no o_host_ready, FSM returns to IDLE, pointer unchanged.
6. Reset asserted during GRANTED with 2 wait states outstanding: o_bus_valid=0 and o_grant=0 immediately; after release, the first grant goes to host 0.
